// File: rtl/player_motion_engine.sv
// Per-player motion state machine: walking, jumping, crouching, attacking and shielding.
// Everything advances once per movement tick, which comes from a free-running counter on the main clock.
module player_motion_engine #(
    parameter int TICK_MAX        = 714285,
    parameter int START_X         = 300,
    parameter int GROUND_Y        = 300,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 608,
    parameter int WALK_STEP       = 2,
    parameter int JUMP_V0         = 12,
    parameter int GRAVITY         = 1,
    parameter int ATTACK_TICKS    = 12,
    parameter int ATTACK_COOLDOWN = 20
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic [6:0] controller_inputs,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       facing,
    output logic [2:0] action,
    output logic       attack_active,
    output logic       shield_active,
    output logic       move_tick
);

    localparam int CW  = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
    localparam int TW  = $clog2(ATTACK_TICKS + 1);
    localparam int CDW = $clog2(ATTACK_COOLDOWN + 1);
    localparam int VW  = 8;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_MAX - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WALK   = 3'd1,
        ST_AIR    = 3'd2,
        ST_CROUCH = 3'd3,
        ST_ATTACK = 3'd4,
        ST_SHIELD = 3'd5
    } action_e;

    action_e               state_r, state_nx_s;
    logic [CW-1:0]         cnt_r;
    logic [9:0]            x_r, x_nx_s, y_r, y_nx_s;
    logic                  facing_r, facing_nx_s;
    logic signed [VW-1:0]  vel_r, vel_nx_s;
    logic [TW-1:0]         timer_r, timer_nx_s;
    logic [CDW-1:0]        cool_r, cool_nx_s;
    logic                  move_tick_r, attack_active_r, shield_active_r;
    logic                  tick_s, left_s, right_s, up_s, down_s, atk_s, shd_s, one_dir_s;
    logic signed [VW-1:0]  air_vel_s, air_vel_nx_s;
    logic signed [10:0]    next_y_s;
    logic                  land_s;
    logic [9:0]            air_y_s, step_x_s;
    action_e               air_state_s;

    // Clamped horizontal step; x saturates at the play-field edges instead of wrapping.
    function automatic logic [9:0] step_x(input logic [9:0] x, input logic lft, input logic rgt);
        logic [9:0] r;
        if (lft && !rgt) begin
            r = (x < 10'(X_MIN + WALK_STEP)) ? 10'(X_MIN) : x - 10'(WALK_STEP);
        end else if (rgt && !lft) begin
            r = (x > 10'(X_MAX - WALK_STEP)) ? 10'(X_MAX) : x + 10'(WALK_STEP);
        end else begin
            r = x;
        end
        return r;
    endfunction

    assign tick_s    = (cnt_r == TICK_LAST);
    assign left_s    = controller_inputs[1];
    assign right_s   = controller_inputs[2];
    assign up_s      = controller_inputs[3];
    assign down_s    = controller_inputs[4];
    assign atk_s     = controller_inputs[5];
    assign shd_s     = controller_inputs[6];
    assign one_dir_s = left_s ^ right_s;

    // Next-state and next-value computation for the coming tick.
    always_comb begin
        state_nx_s  = state_r;
        x_nx_s      = x_r;
        y_nx_s      = y_r;
        facing_nx_s = facing_r;
        vel_nx_s    = vel_r;
        timer_nx_s  = timer_r;
        cool_nx_s   = (cool_r != {CDW{1'b0}}) ? cool_r - CDW'(1'b1) : cool_r;
        step_x_s    = step_x(x_r, left_s, right_s);

        // The takeoff tick already performs the first airborne step at JUMP_V0.
        air_vel_s    = (state_r == ST_AIR) ? vel_r : VW'(JUMP_V0);
        next_y_s     = $signed({1'b0, y_r}) - {{(11-VW){air_vel_s[VW-1]}}, air_vel_s};
        land_s       = (next_y_s >= $signed(11'(GROUND_Y)));
        air_y_s      = land_s ? 10'(GROUND_Y) : next_y_s[9:0];
        air_vel_nx_s = land_s ? {VW{1'b0}} : air_vel_s - VW'(GRAVITY);
        air_state_s  = land_s ? ST_IDLE : ST_AIR;

        case (state_r)
            ST_IDLE, ST_WALK: begin
                if (shd_s) begin
                    state_nx_s = ST_SHIELD;
                end else if (atk_s && (cool_r == {CDW{1'b0}})) begin
                    state_nx_s = ST_ATTACK;
                    timer_nx_s = TW'(ATTACK_TICKS);
                end else if (up_s) begin
                    state_nx_s  = air_state_s;
                    x_nx_s      = step_x_s;
                    facing_nx_s = one_dir_s ? right_s : facing_r;
                    y_nx_s      = air_y_s;
                    vel_nx_s    = air_vel_nx_s;
                end else if (down_s) begin
                    state_nx_s = ST_CROUCH;
                end else if (one_dir_s) begin
                    state_nx_s  = ST_WALK;
                    x_nx_s      = step_x_s;
                    facing_nx_s = right_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_AIR: begin
                state_nx_s  = air_state_s;
                x_nx_s      = step_x_s;
                facing_nx_s = one_dir_s ? right_s : facing_r;
                y_nx_s      = air_y_s;
                vel_nx_s    = air_vel_nx_s;
            end
            ST_CROUCH: begin
                y_nx_s = 10'(GROUND_Y);
                if (shd_s) begin
                    state_nx_s = ST_SHIELD;
                end else if (!down_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_CROUCH;
                end
            end
            ST_ATTACK: begin
                if (timer_r <= TW'(1'b1)) begin
                    state_nx_s = ST_IDLE;
                    timer_nx_s = {TW{1'b0}};
                    cool_nx_s  = CDW'(ATTACK_COOLDOWN);
                end else begin
                    timer_nx_s = timer_r - TW'(1'b1);
                end
            end
            ST_SHIELD: begin
                if (!shd_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SHIELD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                vel_nx_s   = {VW{1'b0}};
                timer_nx_s = {TW{1'b0}};
            end
        endcase
    end

    // Free-running movement tick counter.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_r <= {CW{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1'b1);
        end
    end

    // Player state registers; they only move on the edge that ends a tick cycle.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r         <= ST_IDLE;
            x_r             <= 10'(START_X);
            y_r             <= 10'(GROUND_Y);
            facing_r        <= 1'b1;
            vel_r           <= {VW{1'b0}};
            timer_r         <= {TW{1'b0}};
            cool_r          <= {CDW{1'b0}};
            move_tick_r     <= 1'b0;
            attack_active_r <= 1'b0;
            shield_active_r <= 1'b0;
        end else begin
            move_tick_r <= tick_s;
            if (tick_s) begin
                state_r         <= state_nx_s;
                x_r             <= x_nx_s;
                y_r             <= y_nx_s;
                facing_r        <= facing_nx_s;
                vel_r           <= vel_nx_s;
                timer_r         <= timer_nx_s;
                cool_r          <= cool_nx_s;
                attack_active_r <= (state_nx_s == ST_ATTACK);
                shield_active_r <= (state_nx_s == ST_SHIELD);
            end
        end
    end

    assign player_x      = x_r;
    assign player_y      = y_r;
    assign facing        = facing_r;
    assign action        = state_r;
    assign attack_active = attack_active_r;
    assign shield_active = shield_active_r;
    assign move_tick     = move_tick_r;

endmodule

// File: tb/tb_player_motion_engine.sv
// Directed plus randomized bench for player_motion_engine with TICK_MAX = 4,
// compared against a tick-level behavioural model of the player rules.
module tb_player_motion_engine;

    localparam logic [6:0] B_L = 7'b0000010;
    localparam logic [6:0] B_R = 7'b0000100;
    localparam logic [6:0] B_U = 7'b0001000;
    localparam logic [6:0] B_D = 7'b0010000;
    localparam logic [6:0] B_A = 7'b0100000;
    localparam logic [6:0] B_S = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst_l;
    logic [6:0] controller_inputs;
    logic [9:0] player_x, player_y;
    logic       facing, attack_active, shield_active, move_tick;
    logic [2:0] action;

    int checks, errors;
    int mx, my, mface, mact, mvel, mtimer, mcool;

    player_motion_engine #(.TICK_MAX(4)) dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .controller_inputs (controller_inputs),
        .player_x          (player_x),
        .player_y          (player_y),
        .facing            (facing),
        .action            (action),
        .attack_active     (attack_active),
        .shield_active     (shield_active),
        .move_tick         (move_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 300; my = 300; mface = 1; mact = 0; mvel = 0; mtimer = 0; mcool = 0;
    endtask

    task automatic model_hstep(input bit l, input bit r);
        if (l && !r) begin
            mx = (mx - 2 < 0) ? 0 : mx - 2;
            mface = 0;
        end else if (r && !l) begin
            mx = (mx + 2 > 608) ? 608 : mx + 2;
            mface = 1;
        end
    endtask

    task automatic model_air();
        my = my - mvel;
        mvel = mvel - 1;
        if (my >= 300) begin
            my = 300; mvel = 0; mact = 0;
        end else begin
            mact = 2;
        end
    endtask

    task automatic model_tick(input logic [6:0] c);
        bit l = c[1], r = c[2], u = c[3], d = c[4], a = c[5], s = c[6];
        int cool_before = mcool;
        if (mcool > 0) mcool--;
        case (mact)
            0, 1: begin
                if (s) mact = 5;
                else if (a && cool_before == 0) begin mact = 4; mtimer = 12; end
                else if (u) begin mvel = 12; model_hstep(l, r); model_air(); end
                else if (d) mact = 3;
                else if (l != r) begin model_hstep(l, r); mact = 1; end
                else mact = 0;
            end
            2: begin model_hstep(l, r); model_air(); end
            3: begin if (s) mact = 5; else if (!d) mact = 0; end
            4: begin
                mtimer--;
                if (mtimer == 0) begin mact = 0; mcool = 20; end
            end
            5: begin if (!s) mact = 0; end
            default: mact = 0;
        endcase
    endtask

    task automatic compare_all();
        check("x", player_x, mx);
        check("y", player_y, my);
        check("facing", facing, mface);
        check("action", action, mact);
        check("attack_active", attack_active, (mact == 4));
        check("shield_active", shield_active, (mact == 5));
        check("move_tick_pulse", move_tick, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_x"}, player_x, 300);
        check({tag, "_y"}, player_y, 300);
        check({tag, "_facing"}, facing, 1);
        check({tag, "_action"}, action, 0);
        check({tag, "_attack"}, attack_active, 0);
        check({tag, "_shield"}, shield_active, 0);
        check({tag, "_move_tick"}, move_tick, 0);
    endtask

    // Called #1 after an edge; the next four edges end exactly one tick period.
    task automatic do_tick(input logic [6:0] c);
        controller_inputs = c;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            check("move_tick_gap", move_tick, 0);
            check("hold_x", player_x, mx);
            check("hold_y", player_y, my);
        end
        @(posedge clk); #1;
        model_tick(c);
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int act_cnt, t, miny;
        logic [6:0] c;
        checks = 0; errors = 0;
        controller_inputs = 7'd0;
        rst_l = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_l = 1'b1;

        for (int i = 0; i < 10; i++) do_tick(7'd0);
        check("idle_x", player_x, 300);
        check("idle_y", player_y, 300);

        act_cnt = 0;
        for (int i = 0; i < 33; i++) begin
            do_tick(B_A);
            if (attack_active) act_cnt++;
        end
        check("attack_len", act_cnt, 12);
        do_tick(B_A);
        check("reattack_21st", attack_active, 1);
        for (int i = 0; i < 12; i++) do_tick(7'd0);

        do_tick(B_R); check("walk_x1", player_x, 302);
        do_tick(B_R); check("walk_x2", player_x, 304);
        do_tick(B_R); check("walk_x3", player_x, 306);
        check("walk_action", action, 1);
        do_tick(B_L | B_R);
        check("lr_x", player_x, 306);
        check("lr_action", action, 0);

        do_tick(B_U);
        check("jump_y0", player_y, 288);
        miny = player_y;
        do_tick(B_A);
        check("jump_y1", player_y, 277);
        t = 1;
        while (action == 3'd2 && t < 40) begin
            do_tick((t % 3 == 0) ? (B_A | B_S | B_U) : 7'd0);
            if (player_y < miny) miny = player_y;
            t++;
        end
        check("land_tick", t, 24);
        check("apex_y", miny, 222);
        check("land_y", player_y, 300);

        for (int i = 0; i < 160; i++) do_tick(B_R);
        check("clamp_right", player_x, 608);
        for (int i = 0; i < 310; i++) do_tick(B_L);
        check("clamp_left", player_x, 0);
        check("clamp_left_face", facing, 0);

        do_tick(B_S | B_D);
        check("shield_wins", action, 5);
        do_tick(B_D);
        do_tick(B_D);
        check("crouch", action, 3);
        do_tick(B_S | B_D);
        do_tick(7'd0);

        do_tick(B_U | B_R);
        for (int i = 0; i < 4; i++) do_tick(7'd0);
        @(posedge clk);
        #2;
        rst_l = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        model_reset();
        do_tick(7'd0);
        do_tick(B_R);

        for (int i = 0; i < 400; i++) begin
            c = 7'($urandom);
            if ($urandom_range(0, 3) != 0) c[6] = 1'b0;
            if ($urandom_range(0, 2) != 0) c[5] = 1'b0;
            do_tick(c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
